instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 16, giving the maximum cycles to wait for IMemAck before re-issuing a request.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-low reset.
REQ-005 IMemReq  output  1  instruction-memory read request, held until acknowledged.
REQ-006 IMemAddr  output  32  word-aligned fetch address, stable while IMemReq=1.
REQ-007 IMemAck  input  1  one-cycle pulse; IMemRdata is valid in the same cycle.
REQ-008 IMemRdata  input  32  fetched instruction word.
REQ-009 Stall  input  1  decoder/datapath cannot accept a new instruction this cycle.
REQ-010 PCSrc  input  1  redirect request (taken branch) from the datapath.
REQ-011 BranchTarget  input  32  redirect address, sampled when PCSrc=1.
REQ-012 Instruction  output  32  registered instruction word presented to the controller.
REQ-013 InstrValid  output  1  Instruction holds a valid, non-flushed word.
REQ-014 PCPlus4  output  32  address of Instruction plus 4, registered alongside it.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DROP and HOLD.
REQ-016 IDLE: entered on reset; go to FETCH on the next edge, with IMemReq=1 and IMemAddr=PC.
REQ-017 FETCH: IMemReq=1; on IMemAck with Stall=0: Instruction<=IMemRdata, PCPlus4<=PC+4, InstrValid<=1, PC<=PC+4, and the next request SHALL issue in the following cycle (one instruction per ack, no bubble beyond memory latency).
REQ-018 FETCH, IMemAck with Stall=1: capture the word and its PC+4 in a one-entry skid buffer, PC<=PC+4, go to HOLD; output registers unchanged.
REQ-019 HOLD: IMemReq=0; when Stall falls, move the skid buffer contents to the output registers, InstrValid=1, go to FETCH.
REQ-020 While Stall=1 and no ack is pending, Instruction, PCPlus4 and InstrValid SHALL hold their values.
REQ-021 PCSrc=1 in any state except IDLE SHALL set PC<=BranchTarget with bits[1:0] forced to 2'b00, clear InstrValid on the next edge, and empty the skid buffer.
REQ-022 If PCSrc=1 while a request is outstanding with no ack that cycle, go to DROP. DROP keeps IMemReq=0, discards the next IMemAck, then goes to FETCH.
REQ-023 If PCSrc=1 and IMemAck=1 in the same cycle, discard the ack data and go directly to FETCH at the new PC.
REQ-024 If PCSrc=1 occurs during DROP, update PC and remain in DROP.
REQ-025 Priority SHALL be Rst > PCSrc > Stall > IMemAck.
REQ-026 PC arithmetic SHALL be 32-bit modulo: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error flag.
REQ-027 A 5-bit wait counter SHALL count FETCH cycles without an ack. At IMEM_TIMEOUT it SHALL drop IMemReq for one cycle and re-issue the request to the same address; the counter clears on ack, redirect or re-issue.
REQ-028 IMemAddr SHALL change only when IMemReq=0 or in the cycle after an ack.

Reset
REQ-029 Asserting Rst low SHALL immediately set PC=RESET_PC, state=IDLE, IMemReq=0, IMemAddr=RESET_PC, Instruction=0, PCPlus4=0, InstrValid=0, skid empty and wait counter=0.
REQ-030 Reset mid-request SHALL abandon the request. An IMemAck arriving during reset or in the IDLE cycle SHALL be ignored.

Verification
REQ-031 Release reset; 1-cycle-latency memory returns 0x8C01_0004 and 0x0000_0820 -> IMemAddr is 0 then 4; Instruction shows those words on consecutive acks; PCPlus4 is 4 then 8; InstrValid=1.
REQ-032 Raise Stall while an ack carrying 0xAC02_0008 arrives -> outputs hold the previous word, FSM enters HOLD, IMemReq=0. Drop Stall -> Instruction=0xAC02_0008 next edge.
REQ-033 PCSrc=1 with BranchTarget=0x0000_0043 while a request is outstanding -> InstrValid=0 next edge; the late ack is discarded; the next IMemAddr is 0x0000_0040.
REQ-034 PCSrc=1 coincident with IMemAck -> that ack's word never appears on Instruction; the next request goes to BranchTarget.
REQ-035 Set RESET_PC=0xFFFF_FFFC and complete one fetch -> PCPlus4=0x0000_0000 and the next IMemAddr is 0.
REQ-036 Withhold IMemAck for 16 cycles -> IMemReq drops for one cycle and re-asserts at the same address. Assert Rst low mid-request -> all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory and presents
// them to the controller, with a one-entry skid buffer, redirect and retry.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [31:0] PCPlus4
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP,
        HOLD
    } state_e;

    localparam logic [4:0] WaitMax = 5'(IMEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pcp4_q, skid_pcp4_d;
    logic        skid_v_q, skid_v_d;
    logic [4:0]  wait_q, wait_d;
    logic        gap_q, gap_d;

    logic [31:0] pc_inc;
    logic [31:0] redir_pc;
    logic        req;
    logic        ack_ok;

    assign pc_inc   = pc_q + 32'd4;
    assign redir_pc = BranchTarget & 32'hFFFF_FFFC;
    assign req      = (state_q == FETCH) && !gap_q;
    assign ack_ok   = IMemAck && req;

    assign IMemReq     = req;
    assign IMemAddr    = pc_q;
    assign Instruction = instr_q;
    assign InstrValid  = valid_q;
    assign PCPlus4     = pcp4_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pcp4_q  <= '0;
            skid_v_q     <= 1'b0;
            wait_q       <= '0;
            gap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
            skid_v_q     <= skid_v_d;
            wait_q       <= wait_d;
            gap_q        <= gap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;
        skid_v_d     = skid_v_q;
        wait_d       = wait_q;
        gap_d        = gap_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (PCSrc) begin
                    pc_d     = redir_pc;
                    valid_d  = 1'b0;
                    skid_v_d = 1'b0;
                    wait_d   = '0;
                    gap_d    = 1'b0;
                    state_d  = (req && !IMemAck) ? DROP : FETCH;
                end else if (ack_ok) begin
                    wait_d = '0;
                    pc_d   = pc_inc;
                    if (Stall) begin
                        skid_instr_d = IMemRdata;
                        skid_pcp4_d  = pc_inc;
                        skid_v_d     = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        instr_d = IMemRdata;
                        pcp4_d  = pc_inc;
                        valid_d = 1'b1;
                    end
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else if (wait_q == WaitMax) begin
                    // one idle cycle, then the same address is requested again
                    gap_d  = 1'b1;
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            DROP: begin
                if (PCSrc) begin
                    pc_d     = redir_pc;
                    valid_d  = 1'b0;
                    skid_v_d = 1'b0;
                    wait_d   = '0;
                end else if (IMemAck || wait_q == WaitMax) begin
                    // a lost ack must not strand us here forever
                    state_d = FETCH;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    pc_d     = redir_pc;
                    valid_d  = 1'b0;
                    skid_v_d = 1'b0;
                    wait_d   = '0;
                    state_d  = FETCH;
                end else if (!Stall && skid_v_q) begin
                    instr_d  = skid_instr_q;
                    pcp4_d   = skid_pcp4_q;
                    valid_d  = 1'b1;
                    skid_v_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural reference model
// checked every cycle, plus literal expectations at key points.
module tb_instr_fetch_unit;

    localparam int TO = 16;

    logic        Clk;
    logic        Rst;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] PCPlus4;

    logic        d2_req;
    logic [31:0] d2_addr;
    logic [31:0] d2_instr;
    logic        d2_valid;
    logic [31:0] d2_p4;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 0;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .IMEM_TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemRdata(IMemRdata),
        .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .Instruction(Instruction), .InstrValid(InstrValid),
        .PCPlus4(PCPlus4)
    );

    instr_fetch_unit #(
        .RESET_PC(32'hFFFF_FFFC),
        .IMEM_TIMEOUT(TO)
    ) dut2 (
        .Clk(Clk), .Rst(Rst),
        .IMemReq(d2_req), .IMemAddr(d2_addr),
        .IMemAck(IMemAck), .IMemRdata(IMemRdata),
        .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .Instruction(d2_instr), .InstrValid(d2_valid),
        .PCPlus4(d2_p4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model
    bit          m_started, m_hold, m_drop, m_gap, m_skid;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_p4, m_sk_instr, m_sk_p4;
    logic        m_valid;

    function automatic logic m_req();
        return m_started && !m_hold && !m_drop && !m_gap;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_started = 0; m_hold = 0; m_drop = 0; m_gap = 0;
            m_skid = 0; m_wait = 0;
            m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0;
            m_valid = 1'b0;
            m_sk_instr = 32'h0; m_sk_p4 = 32'h0;
        end else if (!m_started) begin
            m_started = 1;
        end else begin
            automatic bit busy = m_req();
            if (PCSrc) begin
                m_pc = {BranchTarget[31:2], 2'b00};
                m_valid = 1'b0;
                m_skid = 0;
                m_wait = 0;
                m_gap = 0;
                if (m_hold) m_hold = 0;
                else if (!m_drop && busy && !IMemAck) m_drop = 1;
            end else if (m_drop) begin
                m_wait = m_wait + 1;
                if (IMemAck || m_wait == TO) begin
                    m_drop = 0;
                    m_wait = 0;
                end
            end else if (m_hold) begin
                if (!Stall) begin
                    m_instr = m_sk_instr;
                    m_p4 = m_sk_p4;
                    m_valid = 1'b1;
                    m_hold = 0;
                    m_skid = 0;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (IMemAck) begin
                m_wait = 0;
                if (Stall) begin
                    m_sk_instr = IMemRdata;
                    m_sk_p4 = m_pc + 4;
                    m_skid = 1;
                    m_hold = 1;
                end else begin
                    m_instr = IMemRdata;
                    m_p4 = m_pc + 4;
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 4;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TO) begin
                    m_gap = 1;
                    m_wait = 0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (run) begin
            chk("req", IMemReq, m_req());
            chk("addr", IMemAddr, m_pc);
            chk("valid", InstrValid, m_valid);
            chk("instr", Instruction, m_instr);
            chk("pcp4", PCPlus4, m_p4);
        end
    end

    task automatic cyc(input logic a, input logic [31:0] d, input logic s,
                       input logic p, input logic [31:0] t);
        IMemAck = a;
        IMemRdata = d;
        Stall = s;
        PCSrc = p;
        BranchTarget = t;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        IMemAck = 1'b0;
        IMemRdata = '0;
        Stall = 1'b0;
        PCSrc = 1'b0;
        BranchTarget = '0;
        repeat (2) @(posedge Clk);
        #1;
        run = 1;
        chk("rst_req", IMemReq, 0);
        chk("rst_addr", IMemAddr, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_d2_addr", d2_addr, 32'hFFFF_FFFC);
        Rst = 1'b1;

        // basic fetch stream
        cyc(0, 0, 0, 0, 0);
        chk("first_req", IMemReq, 1);
        chk("first_addr", IMemAddr, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h8C01_0004, 0, 0, 0);
        chk("w1_instr", Instruction, 32'h8C01_0004);
        chk("w1_p4", PCPlus4, 4);
        chk("w1_valid", InstrValid, 1);
        chk("w1_addr", IMemAddr, 4);
        chk("wrap_p4", d2_p4, 32'h0000_0000);
        chk("wrap_addr", d2_addr, 32'h0000_0000);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h0000_0820, 0, 0, 0);
        chk("w2_instr", Instruction, 32'h0000_0820);
        chk("w2_p4", PCPlus4, 8);
        chk("wrap2_p4", d2_p4, 32'h0000_0004);

        // ack under stall goes to the skid buffer
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'hAC02_0008, 1, 0, 0);
        chk("hold_instr", Instruction, 32'h0000_0820);
        chk("hold_req", IMemReq, 0);
        cyc(0, 0, 1, 0, 0);
        chk("hold2_instr", Instruction, 32'h0000_0820);
        cyc(0, 0, 0, 0, 0);
        chk("skid_instr", Instruction, 32'hAC02_0008);
        chk("skid_p4", PCPlus4, 32'h0000_000C);
        chk("skid_addr", IMemAddr, 32'h0000_000C);

        // redirect with request outstanding, late ack dropped
        cyc(0, 0, 0, 1, 32'h0000_0043);
        chk("drop_valid", InstrValid, 0);
        chk("drop_req", IMemReq, 0);
        chk("drop_addr", IMemAddr, 32'h0000_0040);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("late_instr", Instruction, 32'hAC02_0008);
        chk("late_req", IMemReq, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h1111_1111, 0, 0, 0);
        chk("br_instr", Instruction, 32'h1111_1111);
        chk("br_p4", PCPlus4, 32'h0000_0044);

        // redirect coincident with ack
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h2222_2222, 0, 1, 32'h0000_0100);
        chk("co_instr", Instruction, 32'h1111_1111);
        chk("co_valid", InstrValid, 0);
        chk("co_addr", IMemAddr, 32'h0000_0100);
        chk("co_req", IMemReq, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h3333_3333, 0, 0, 0);
        chk("co2_p4", PCPlus4, 32'h0000_0104);

        // stall with no ack, then redirect while holding flushes the skid
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 32'h4444_4444, 1, 0, 0);
        cyc(0, 0, 1, 1, 32'h0000_0200);
        chk("flush_valid", InstrValid, 0);
        chk("flush_instr", Instruction, 32'h3333_3333);
        cyc(0, 0, 0, 0, 0);
        chk("flush2_instr", Instruction, 32'h3333_3333);
        cyc(1, 32'h5555_5555, 0, 0, 0);
        chk("flush_p4", PCPlus4, 32'h0000_0204);

        // redirect again while dropping
        cyc(0, 0, 0, 1, 32'h0000_0300);
        cyc(0, 0, 0, 1, 32'h0000_0306);
        chk("dd_addr", IMemAddr, 32'h0000_0304);
        chk("dd_req", IMemReq, 0);
        cyc(1, 32'hBAD0_BAD0, 0, 0, 0);
        cyc(1, 32'h6666_6666, 0, 0, 0);
        chk("dd_instr", Instruction, 32'h6666_6666);
        chk("dd_p4", PCPlus4, 32'h0000_0308);

        // timeout and re-issue
        for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0);
        chk("to_req", IMemReq, 0);
        chk("to_addr", IMemAddr, 32'h0000_0308);
        cyc(0, 0, 0, 0, 0);
        chk("re_req", IMemReq, 1);
        chk("re_addr", IMemAddr, 32'h0000_0308);
        cyc(1, 32'h7777_7777, 0, 0, 0);
        chk("re_instr", Instruction, 32'h7777_7777);

        // asynchronous reset mid-request, acks during reset/idle ignored
        #2;
        Rst = 1'b0;
        #1;
        chk("ar_req", IMemReq, 0);
        chk("ar_addr", IMemAddr, 0);
        chk("ar_instr", Instruction, 0);
        chk("ar_p4", PCPlus4, 0);
        chk("ar_valid", InstrValid, 0);
        IMemAck = 1'b1;
        IMemRdata = 32'h9999_9999;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        cyc(1, 32'h9999_9999, 0, 0, 0);
        chk("idle_ack_instr", Instruction, 0);
        chk("idle_ack_valid", InstrValid, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'hABCD_0123, 0, 0, 0);
        chk("post_instr", Instruction, 32'hABCD_0123);
        chk("post_p4", PCPlus4, 4);

        cyc(0, 0, 0, 0, 0);
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
